// File: rtl/intrusion_decision_ack_gate.sv
// Intrusion decision ACK gate: pairs ML intrusion decisions with pending RX
// message descriptors, in order, and issues ACK/NAK commands. It NAKs on a QPN
// mismatch and on a decision that arrives too late. Everything runs on nclk.

// Small synchronous FIFO with a registered occupancy count; DEPTH is a power of two.
module intrusion_decision_ack_gate_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers and occupancy; a push and a pop together on a full FIFO keep it full.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage is not reset; only the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module intrusion_decision_ack_gate #(
  parameter int DESC_DEPTH     = 16,
  parameter int DEC_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        nclk,
  input  logic        nrst,
  input  logic        s_rx_meta_valid,
  output logic        s_rx_meta_ready,
  input  logic [55:0] s_rx_meta_data,
  input  logic        s_rdma_intrusion_decision_valid,
  output logic        s_rdma_intrusion_decision_ready,
  input  logic [24:0] s_rdma_intrusion_decision_data,
  output logic        m_ack_cmd_valid,
  input  logic        m_ack_cmd_ready,
  output logic [49:0] m_ack_cmd_data,
  output logic [31:0] cnt_ack_o,
  output logic [31:0] cnt_nak_o,
  output logic [31:0] cnt_mismatch_o,
  output logic [31:0] cnt_timeout_o,
  output logic        dec_overflow_o
);
  localparam int DESC_CW = $clog2(DESC_DEPTH) + 1;
  localparam int DEC_CW  = $clog2(DEC_DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MATCH, ST_EMIT} state_t;

  state_t state_q, state_base, state_d;

  logic [55:0]        desc_head;
  logic [24:0]        dec_head;
  logic [DESC_CW-1:0] desc_count, desc_cnt_next;
  logic [DEC_CW-1:0]  dec_count, dec_cnt_next;
  logic desc_empty, desc_full, dec_empty, dec_full;
  logic desc_push, desc_pop, dec_push_req, dec_push, dec_pop;
  logic timeout_fire, qpn_eq;

  logic        cmd_valid_q, cmd_valid_d;
  logic [49:0] cmd_data_q, cmd_data_d;
  logic [7:0]  skip_q, skip_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] cnt_ack_q, cnt_ack_d, cnt_nak_q, cnt_nak_d;
  logic [31:0] cnt_mismatch_q, cnt_mismatch_d, cnt_timeout_q, cnt_timeout_d;
  logic        overflow_q, overflow_d;
  logic        unused_opcode;

  // The opcode rides along in the descriptor but takes no part in matching.
  assign unused_opcode = &{1'b0, desc_head[7:0]};

  // The decision source ignores ready, so ready only reflects reset.
  assign s_rx_meta_ready                 = !nrst && !desc_full;
  assign s_rdma_intrusion_decision_ready = !nrst;
  assign desc_push    = s_rx_meta_valid && s_rx_meta_ready;
  assign dec_push_req = s_rdma_intrusion_decision_valid && !nrst;
  assign dec_push     = dec_push_req && (!dec_full || dec_pop);

  assign timeout_fire = (state_q == ST_IDLE) && !desc_empty && dec_empty &&
                        ((wait_q + 16'd1) == 16'(TIMEOUT_CYCLES));
  assign qpn_eq = (desc_head[55:32] == dec_head[24:1]);

  intrusion_decision_ack_gate_fifo #(.WIDTH(56), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk(nclk), .rst(nrst), .push(desc_push), .pop(desc_pop), .din(s_rx_meta_data),
    .dout(desc_head), .count(desc_count), .empty(desc_empty), .full(desc_full)
  );

  intrusion_decision_ack_gate_fifo #(.WIDTH(25), .DEPTH(DEC_DEPTH)) u_dec_fifo (
    .clk(nclk), .rst(nrst), .push(dec_push), .pop(dec_pop),
    .din(s_rdma_intrusion_decision_data),
    .dout(dec_head), .count(dec_count), .empty(dec_empty), .full(dec_full)
  );

  // Per-state actions: timeout, skip discard, head matching, command handshake.
  always_comb begin
    state_base     = state_q;
    cmd_data_d     = cmd_data_q;
    desc_pop       = 1'b0;
    dec_pop        = 1'b0;
    skip_d         = skip_q;
    cnt_ack_d      = cnt_ack_q;
    cnt_nak_d      = cnt_nak_q;
    cnt_mismatch_d = cnt_mismatch_q;
    cnt_timeout_d  = cnt_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (timeout_fire) begin
          cmd_data_d    = {desc_head[55:32], desc_head[31:8], 1'b1, 1'b1};
          desc_pop      = 1'b1;
          skip_d        = (skip_q == 8'hFF) ? skip_q : skip_q + 8'd1;
          cnt_timeout_d = cnt_timeout_q + 32'd1;
          state_base    = ST_EMIT;
        end else if ((skip_q != 8'd0) && !dec_empty) begin
          dec_pop = 1'b1;
          skip_d  = skip_q - 8'd1;
        end
      end
      ST_MATCH: begin
        cmd_data_d = {desc_head[55:32], desc_head[31:8], !(qpn_eq && dec_head[0]), 1'b0};
        desc_pop   = 1'b1;
        dec_pop    = 1'b1;
        if (!qpn_eq) cnt_mismatch_d = cnt_mismatch_q + 32'd1;
        state_base = ST_EMIT;
      end
      ST_EMIT: begin
        if (m_ack_cmd_ready) begin
          if (cmd_data_q[1]) cnt_nak_d = cnt_nak_q + 32'd1;
          else               cnt_ack_d = cnt_ack_q + 32'd1;
          state_base = ST_IDLE;
        end
      end
      default: state_base = ST_IDLE;
    endcase

    if (desc_pop || !dec_empty)                 wait_d = 16'd0;
    else if (state_q == ST_IDLE && !desc_empty) wait_d = wait_q + 16'd1;
    else                                        wait_d = wait_q;

    overflow_d = overflow_q || (dec_push_req && dec_full && !dec_pop);
  end

  // Enter MATCH as soon as both heads will be present next cycle, so a pair
  // written at N-1 is matched at N and the command is valid at N+1.
  always_comb begin
    desc_cnt_next = desc_count + DESC_CW'(desc_push) - DESC_CW'(desc_pop);
    dec_cnt_next  = dec_count + DEC_CW'(dec_push) - DEC_CW'(dec_pop);
    state_d       = state_base;
    if (state_base == ST_IDLE && desc_cnt_next != '0 && dec_cnt_next != '0 && skip_d == 8'd0)
      state_d = ST_MATCH;
    cmd_valid_d = (state_d == ST_EMIT);
  end

  // FSM, output command register, counters and sticky overflow flag.
  always_ff @(posedge nclk) begin
    if (nrst) begin
      state_q        <= ST_IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_data_q     <= '0;
      skip_q         <= '0;
      wait_q         <= '0;
      cnt_ack_q      <= '0;
      cnt_nak_q      <= '0;
      cnt_mismatch_q <= '0;
      cnt_timeout_q  <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_data_q     <= cmd_data_d;
      skip_q         <= skip_d;
      wait_q         <= wait_d;
      cnt_ack_q      <= cnt_ack_d;
      cnt_nak_q      <= cnt_nak_d;
      cnt_mismatch_q <= cnt_mismatch_d;
      cnt_timeout_q  <= cnt_timeout_d;
      overflow_q     <= overflow_d;
    end
  end

  assign m_ack_cmd_valid = cmd_valid_q;
  assign m_ack_cmd_data  = cmd_data_q;
  assign cnt_ack_o       = cnt_ack_q;
  assign cnt_nak_o       = cnt_nak_q;
  assign cnt_mismatch_o  = cnt_mismatch_q;
  assign cnt_timeout_o   = cnt_timeout_q;
  assign dec_overflow_o  = overflow_q;
endmodule

// File: tb/tb_intrusion_decision_ack_gate.sv
// Testbench for intrusion_decision_ack_gate: table of matched pairs plus
// directed sequences for backpressure, timeout, overflow and reset.
module tb_intrusion_decision_ack_gate;
  localparam int TO = 16;

  logic        nclk, nrst;
  logic        rx_valid, rx_ready;
  logic [55:0] rx_data;
  logic        dec_valid, dec_ready;
  logic [24:0] dec_data;
  logic        cmd_valid, cmd_ready;
  logic [49:0] cmd_data;
  logic [31:0] cnt_ack, cnt_nak, cnt_mis, cnt_to;
  logic        ovf;

  int checks, failures;
  int exp_ack, exp_nak, exp_mis, exp_to;

  typedef struct {
    logic [23:0] qpn;
    logic [23:0] psn;
    logic [7:0]  opc;
    logic [23:0] dec_qpn;
    logic        acc;
    logic        exp_nak;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[6];

  intrusion_decision_ack_gate #(.DESC_DEPTH(16), .DEC_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .nclk(nclk), .nrst(nrst),
    .s_rx_meta_valid(rx_valid), .s_rx_meta_ready(rx_ready), .s_rx_meta_data(rx_data),
    .s_rdma_intrusion_decision_valid(dec_valid),
    .s_rdma_intrusion_decision_ready(dec_ready),
    .s_rdma_intrusion_decision_data(dec_data),
    .m_ack_cmd_valid(cmd_valid), .m_ack_cmd_ready(cmd_ready), .m_ack_cmd_data(cmd_data),
    .cnt_ack_o(cnt_ack), .cnt_nak_o(cnt_nak), .cnt_mismatch_o(cnt_mis),
    .cnt_timeout_o(cnt_to), .dec_overflow_o(ovf)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitValid(input string name, input int budget, output bit seen);
    int n = 0;
    seen = cmd_valid;
    while (!seen && n < budget) begin
      @(negedge nclk);
      n++;
      seen = cmd_valid;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: valid not seen within %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic collectCmd(input string name, input logic [49:0] exp);
    bit seen;
    waitValid(name, 20, seen);
    if (seen) begin
      checkOutput(name, 64'(cmd_data), 64'(exp));
      @(negedge nclk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge nclk);
    rx_valid = 1'b1;
    rx_data  = {v.qpn, v.psn, v.opc};
    @(negedge nclk);
    rx_valid  = 1'b0;
    dec_valid = 1'b1;
    dec_data  = {v.dec_qpn, v.acc};
    @(negedge nclk);
    dec_valid = 1'b0;
  endtask

  // Command must appear exactly two cycles after the decision write.
  task automatic runVector(input vec_t v);
    applyStimulus(v);
    checkOutput("vec_lat_early", 64'(cmd_valid), 64'd0);
    @(negedge nclk);
    checkOutput("vec_valid", 64'(cmd_valid), 64'd1);
    checkOutput("vec_data", 64'(cmd_data), 64'({v.qpn, v.psn, v.exp_nak, 1'b0}));
    if (v.exp_nak) exp_nak++;
    else           exp_ack++;
    if (v.exp_mis) exp_mis++;
    @(negedge nclk);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cnt_ack"}, 64'(cnt_ack), 64'(exp_ack));
    checkOutput({tag, "_cnt_nak"}, 64'(cnt_nak), 64'(exp_nak));
    checkOutput({tag, "_cnt_mismatch"}, 64'(cnt_mis), 64'(exp_mis));
    checkOutput({tag, "_cnt_timeout"}, 64'(cnt_to), 64'(exp_to));
  endtask

  initial begin
    logic [49:0] bp_exp [3];
    bit seen;
    bit any_valid;

    checks = 0; failures = 0;
    exp_ack = 0; exp_nak = 0; exp_mis = 0; exp_to = 0;
    nrst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    dec_valid = 1'b0; dec_data = '0; cmd_ready = 1'b0;

    vecs[0] = '{24'h000011, 24'h000005, 8'h04, 24'h000011, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{24'h000022, 24'h000100, 8'h04, 24'h000022, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{24'h000033, 24'h000101, 8'h0A, 24'h000044, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{24'hABCDEF, 24'hFFFFFF, 8'h11, 24'hABCDEF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{24'h000001, 24'h000000, 8'h29, 24'h800001, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{24'hFFFFFF, 24'h123456, 8'hFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge nclk);
    checkOutput("rst_rx_ready", 64'(rx_ready), 64'd0);
    checkOutput("rst_dec_ready", 64'(dec_ready), 64'd0);
    checkOutput("rst_valid", 64'(cmd_valid), 64'd0);
    checkOutput("rst_data", 64'(cmd_data), 64'd0);
    nrst = 1'b0;
    @(negedge nclk);
    checkOutput("post_rst_rx_ready", 64'(rx_ready), 64'd1);
    checkOutput("post_rst_dec_ready", 64'(dec_ready), 64'd1);
    checkOutput("post_rst_ovf", 64'(ovf), 64'd0);
    checkCounters("post_rst");
    cmd_ready = 1'b1;

    // Table of matched pairs: ACK, reject, mismatch.
    for (int i = 0; i < 6; i++) runVector(vecs[i]);
    checkCounters("table");

    // Backpressure: three queued pairs, ready low for 10 cycles.
    cmd_ready = 1'b0;
    bp_exp[0] = {24'h000201, 24'h000A01, 1'b0, 1'b0};
    bp_exp[1] = {24'h000202, 24'h000A02, 1'b1, 1'b0};
    bp_exp[2] = {24'h000203, 24'h000A03, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge nclk);
      rx_valid = 1'b1;
      rx_data  = {24'h000201 + 24'(i), 24'h000A01 + 24'(i), 8'h04};
    end
    @(negedge nclk);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dec_valid = 1'b1;
      dec_data  = {24'h000201 + 24'(i), (i != 1)};
      @(negedge nclk);
    end
    dec_valid = 1'b0;
    waitValid("bp_first", 10, seen);
    for (int i = 0; i < 10; i++) begin
      @(negedge nclk);
      checkOutput("bp_hold_valid", 64'(cmd_valid), 64'd1);
      checkOutput("bp_hold_data", 64'(cmd_data), 64'(bp_exp[0]));
    end
    cmd_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge nclk);
      checkOutput("bp_gap", 64'(cmd_valid), 64'd0);
      @(negedge nclk);
      checkOutput("bp_next_valid", 64'(cmd_valid), 64'd1);
      checkOutput("bp_next_data", 64'(cmd_data), 64'(bp_exp[i]));
    end
    @(negedge nclk);
    checkOutput("bp_done", 64'(cmd_valid), 64'd0);
    exp_ack += 2; exp_nak += 1;
    checkCounters("bp");

    // Timeout: descriptor with no decision, then the late decision is discarded.
    @(negedge nclk);
    rx_valid = 1'b1;
    rx_data  = {24'h000055, 24'h000077, 8'h04};
    @(negedge nclk);
    rx_valid = 1'b0;
    repeat (TO - 1) @(negedge nclk);
    checkOutput("to_early", 64'(cmd_valid), 64'd0);
    @(negedge nclk);
    checkOutput("to_valid", 64'(cmd_valid), 64'd1);
    checkOutput("to_data", 64'(cmd_data), 64'({24'h000055, 24'h000077, 1'b1, 1'b1}));
    exp_nak++; exp_to++;
    @(negedge nclk);
    dec_valid = 1'b1;
    dec_data  = {24'h000055, 1'b1};
    @(negedge nclk);
    dec_valid = 1'b0;
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge nclk);
      any_valid |= cmd_valid;
    end
    checkOutput("late_dec_no_cmd", 64'(any_valid), 64'd0);
    checkOutput("skip_zero", 64'(dut.skip_q), 64'd0);
    checkCounters("to");
    runVector('{24'h000056, 24'h000078, 8'h04, 24'h000056, 1'b1, 1'b0, 1'b0});

    // Timeout wins over a decision written on the firing cycle.
    @(negedge nclk);
    rx_valid = 1'b1;
    rx_data  = {24'h000066, 24'h000088, 8'h04};
    @(negedge nclk);
    rx_valid = 1'b0;
    repeat (TO - 1) @(negedge nclk);
    checkOutput("prec_early", 64'(cmd_valid), 64'd0);
    dec_valid = 1'b1;
    dec_data  = {24'h000066, 1'b1};
    @(negedge nclk);
    dec_valid = 1'b0;
    checkOutput("prec_valid", 64'(cmd_valid), 64'd1);
    checkOutput("prec_data", 64'(cmd_data), 64'({24'h000066, 24'h000088, 1'b1, 1'b1}));
    exp_nak++; exp_to++;
    any_valid = 1'b0;
    repeat (8) begin
      @(negedge nclk);
      any_valid |= cmd_valid;
    end
    checkOutput("prec_no_second_cmd", 64'(any_valid), 64'd0);
    checkOutput("prec_skip_zero", 64'(dut.skip_q), 64'd0);
    checkCounters("prec");

    // Decision overflow: nine decisions, eight kept.
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge nclk);
      if (i == 8) begin
        checkOutput("ovf_before", 64'(ovf), 64'd0);
        checkOutput("dec_ready_when_full", 64'(dec_ready), 64'd1);
      end
      dec_valid = 1'b1;
      dec_data  = {24'h000100 + 24'(i), i[0]};
    end
    @(negedge nclk);
    dec_valid = 1'b0;
    checkOutput("ovf_set", 64'(ovf), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge nclk);
      rx_valid = 1'b1;
      rx_data  = {24'h000100 + 24'(i), 24'h000300 + 24'(i), 8'h04};
    end
    @(negedge nclk);
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      collectCmd("ovf_cmd", {24'h000100 + 24'(i), 24'h000300 + 24'(i), !i[0], 1'b0});
      if (i[0]) exp_ack++;
      else      exp_nak++;
    end
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge nclk);
      any_valid |= cmd_valid;
    end
    checkOutput("ovf_no_ninth", 64'(any_valid), 64'd0);
    checkOutput("ovf_sticky", 64'(ovf), 64'd1);
    checkCounters("ovf");

    // Descriptor FIFO full, then reset in the middle of it.
    for (int i = 0; i < 16; i++) begin
      @(negedge nclk);
      checkOutput("full_ready_hi", 64'(rx_ready), 64'd1);
      rx_valid = 1'b1;
      rx_data  = {24'h000400 + 24'(i), 24'h000500 + 24'(i), 8'h04};
    end
    @(negedge nclk);
    rx_valid = 1'b0;
    checkOutput("full_ready_lo", 64'(rx_ready), 64'd0);
    nrst = 1'b1;
    @(negedge nclk);
    checkOutput("mid_rst_valid", 64'(cmd_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(cmd_data), 64'd0);
    checkOutput("mid_rst_ovf", 64'(ovf), 64'd0);
    checkOutput("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    checkOutput("mid_rst_dec_ready", 64'(dec_ready), 64'd0);
    exp_ack = 0; exp_nak = 0; exp_mis = 0; exp_to = 0;
    checkCounters("mid_rst");
    nrst = 1'b0;
    @(negedge nclk);
    checkOutput("rerst_rx_ready", 64'(rx_ready), 64'd1);
    any_valid = 1'b0;
    repeat (TO + 8) begin
      @(negedge nclk);
      any_valid |= cmd_valid;
    end
    checkOutput("rerst_fifo_empty", 64'(any_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intrusion_decision_ack_gate.md
# intrusion_decision_ack_gate

Consumes the per-message ML intrusion decisions (`{QPN, acceptable}`) on the RDMA receive path and turns them into ACK/NAK commands for the RDMA ACK generator. It pairs each decision, in order, with a pending receive-message descriptor, and NAKs fail-safe on QPN mismatch or decision timeout. The block sits between the intrusion decider / RX packet processor and the ACK/NAK generation logic, in the `nclk` domain.

## Interface
Parameters:
- `DESC_DEPTH`, 16: pending-descriptor FIFO entries (power of two, ≥2).
- `DEC_DEPTH`, 8: decision FIFO entries (power of two, ≥2).
- `TIMEOUT_CYCLES`, 1024: head-descriptor wait limit in cycles (1..65535).

Ports:
- `nclk`  in  1  clock.
- `nrst`  in  1  reset. Synchronous and active-high; one clock; reset is synchronous and active-high.
- `s_rx_meta`  metaIntf.s  56  message-last descriptor. `[55:32]` QPN, `[31:8]` PSN, `[7:0]` opcode. `ready = !desc_full`.
- `s_rdma_intrusion_decision`  metaIntf.s  25  decision word. `[24:1]` QPN, `[0]` acceptable.
- `m_ack_cmd`  metaIntf.m  50  command word. `[49:26]` QPN, `[25:2]` PSN, `[1]` nak, `[0]` timeout.
- `cnt_ack_o`  out  32  ACKs issued.
- `cnt_nak_o`  out  32  NAKs issued, all causes.
- `cnt_mismatch_o`  out  32  QPN mismatches.
- `cnt_timeout_o`  out  32  timeouts.
- `dec_overflow_o`  out  1  sticky: a decision was dropped because the decision FIFO was full.

## Operation
- **Descriptor FIFO.** Pushes on `s_rx_meta.valid & ready`. The opcode is stored but not used for matching.
- **Decision FIFO.**
  - `s_rdma_intrusion_decision.ready` is 1 whenever `nrst`=0, because the upstream source ignores ready.
  - Push on `valid`. If valid arrives while the FIFO is full, the word is dropped and `dec_overflow_o` is set, cleared only by reset.
- **Skip counter `skip_cnt`.**
  - 8-bit, saturating at 255.
  - Incremented on each timeout.
  - While `skip_cnt>0`, the decision FIFO head is popped and discarded, and `skip_cnt` is decremented. No command is issued.
- **FSM states:** IDLE, MATCH, EMIT.
  - **IDLE → MATCH:** when both FIFOs are non-empty and `skip_cnt`=0.
  - **IDLE → EMIT (timeout):** when the descriptor FIFO is non-empty, the decision FIFO is empty, and the wait counter reaches `TIMEOUT_CYCLES`.
  - **MATCH:** compares the QPNs at the two FIFO heads, loads the output register, pops both heads, then goes to EMIT.
    - Equal QPN and acceptable=1 → ACK (nak=0).
    - Equal QPN and acceptable=0 → NAK.
    - Unequal QPN → NAK, and `cnt_mismatch` increments.
  - **Timeout path:** loads the head descriptor with nak=1 and timeout=1, pops the descriptor only, increments `skip_cnt` and `cnt_timeout`, then goes to EMIT.
  - **EMIT:** holds `m_ack_cmd.valid`=1 with stable data until `ready`, then returns to IDLE.
  - `cnt_ack`/`cnt_nak` increment on the accepted handshake.
- **Wait counter.**
  - 16-bit.
  - Counts in IDLE while the descriptor FIFO is non-empty and the decision FIFO is empty.
  - Clears on any pop of a descriptor, or whenever the decision FIFO is non-empty.
- **Counters.** All 32-bit counters wrap modulo 2^32.

## Timing
- **Reset values:**
  - `m_ack_cmd.valid`=0, `m_ack_cmd.data`=0.
  - All counters 0.
  - `dec_overflow_o`=0.
  - FIFOs empty, `skip_cnt`=0, FSM in IDLE.
  - `s_rx_meta.ready` and the decision ready are 0 during reset and 1 in the first cycle after reset.
- **Latency.** With both heads available at cycle N (FIFO write at N-1), MATCH runs at N and `m_ack_cmd.valid` rises at N+1. Throughput is one command per 2 cycles when ready is held high.
- **FIFOs:** first-word latency is 1 cycle; simultaneous push and pop on a full FIFO is allowed for both FIFOs.
- **Timeout firing.** A timeout fires on the cycle the counter equals `TIMEOUT_CYCLES` (the `TIMEOUT_CYCLES`-th consecutive waiting cycle). If a decision is written on that same cycle, the timeout still takes precedence.
- **Skip discard** costs 1 cycle per discarded word, taken in IDLE.
- **Reset mid-EMIT:** valid drops in the same cycle reset is sampled; the pending command is lost.

## Test plan
- **ACK match:** descriptor `{QPN=0x000011, PSN=0x000005}` followed by decision `{0x000011,1}` → one `m_ack_cmd` with data `{0x000011, 0x000005, nak=0, to=0}` exactly 2 cycles after the decision write; `cnt_ack`=1.
- **Reject and mismatch:** descriptors for QPN 0x22 then 0x33; decisions `{0x22,0}` then `{0x44,1}` → NAK for 0x22, then NAK for 0x33; `cnt_nak`=2, `cnt_mismatch`=1.
- **Timeout then late decision:** `TIMEOUT_CYCLES`=16, descriptor QPN 0x55 with no decision → NAK with timeout=1 sixteen cycles after the descriptor reaches the head. A later decision `{0x55,1}` is discarded with no command; `cnt_timeout`=1, `skip_cnt` returns to 0.
- **Backpressure:** hold `m_ack_cmd.ready`=0 for 10 cycles while 3 matched pairs are queued → data stays stable and valid stays high. After release, 3 commands are issued in order, 2 cycles apart.
- **Decision overflow:** `DEC_DEPTH`=8 and no descriptors; write 9 decisions → `dec_overflow_o`=1 and 8 entries are retained. Then 8 descriptors with matching QPNs → 8 commands.
- **Descriptor full:** write 16 descriptors with no decisions → `s_rx_meta.ready`=0. Assert reset mid-stream → all outputs return to their reset values on the next edge.
